rom_pixel_streamer: RTL and testbench
=====================================

# rom_pixel_streamer

Reads a stored image out of the on-chip image ROM (13-bit address, 32-bit words, registered output) and delivers it as a raster-ordered RGB565 pixel stream with valid/ready flow control. It sits directly downstream of the ROM instance and upstream of the video processing/overlay pipeline. It issues ROM addresses, compensates for the fixed ROM read latency, buffers returned words against backpressure, and unpacks each 32-bit word into two 16-bit pixels, tagging frame and line boundaries.

## Interface
Parameters:
- ADDR_WIDTH, 13, ROM address width; word count = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, ROM word width; fixed to 2 × PIX_WIDTH.
- PIX_WIDTH, 16, pixel width (RGB565).
- H_PIX, 128, pixels per line; H_PIX × V_LINES = 2 × 2**ADDR_WIDTH.
- V_LINES, 128, lines per frame.
- RD_LATENCY, 2, clk edges from `rom_addr` change to valid `rom_rd_data`; 2 with ROM output register enabled.
- FIFO_DEPTH, 4, word buffer entries; power of two, ≥ RD_LATENCY+2.

Ports:
- clk  in  1  system clock; ROM shares it.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins one frame readout.
- rom_addr  out  ADDR_WIDTH  ROM word address, registered.
- rom_rd_data  in  DATA_WIDTH  ROM read data.
- pix_data  out  PIX_WIDTH  current pixel.
- pix_valid  out  1  pix_data and flags valid.
- pix_ready  in  1  downstream accepts; transfer = valid & ready.
- pix_sof  out  1  qualifies pixel 0 of frame.
- pix_eol  out  1  qualifies last pixel of each line.
- pix_eof  out  1  qualifies last pixel of frame.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after final transfer.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: on start, rom_addr←0, word issue counter←0, pixel x/y counters←0, busy←1, go to RUN. start outside IDLE is ignored.
- RUN: a read is issued on an edge when credit = FIFO_DEPTH − (fifo_count + inflight) > 0; issuing advances rom_addr on the next issue. Inflight tracked by an RD_LATENCY-deep valid shift register; the word is written to the FIFO on the edge its valid bit exits the pipe. After issuing address 2**ADDR_WIDTH−1, go to DRAIN; rom_addr holds last value.
- DRAIN: no issues; leave to IDLE on the transfer with pix_eof; done←1 for one cycle, busy←0.
- Unpack: each FIFO word yields pixel [15:0] first, then [31:16]; the word is popped on the transfer of its upper half.
- Flags: x counts 0..H_PIX−1, y counts 0..V_LINES−1 on each transfer. pix_sof = (x==0 && y==0), pix_eol = (x==H_PIX−1), pix_eof = eol && (y==V_LINES−1).
- Credit rule guarantees no FIFO overflow; words returning while pix_ready is low are never dropped.
- Reset values: rom_addr 0, pix_data 0, pix_valid 0, all flags 0, busy 0, done 0, FIFO empty, state IDLE. rst mid-frame aborts immediately; no done pulse; next start restarts at address 0.

## Timing
- start sampled at edge E0: rom_addr = 0 after E0; word 0 enters FIFO at E0+RD_LATENCY; pix_valid high in the cycle after that edge (pixel 0 with pix_sof).
- Steady state with pix_ready held high: one pixel per clk, no bubbles after first pixel; full frame = 2**(ADDR_WIDTH+1) transfers.
- pix_valid never drops without a transfer; pix_data and flags stable while valid & !ready.
- done asserted in the cycle after the eof transfer edge; start in that done cycle is accepted.
- Issue stall: rom_addr holds while credit = 0; resumes the edge after a pop frees credit.

## Test plan
- Reset, pulse start, pix_ready=1, ROM model word n = {16'(2n+1),16'(2n)}: expect pixels 0,1,2…16383 in order, first valid 2 cycles after start, 16384 contiguous transfers, done once.
- Flags: check pix_sof only on pixel 0, pix_eol on pixels 127, 255, …, pix_eof only on 16383; exactly 128 eol pulses.
- Random pix_ready (50%): same pixel sequence, no loss or duplication; data stable during stalls; fifo_count+inflight never exceeds 4.
- pix_ready low for 100 cycles after first pixel: rom_addr stops advancing by address 3; resumes correctly; pixel 1 follows pixel 0.
- start pulses while busy: ignored, sequence unchanged; start in done cycle: second frame begins at address 0.
- rst asserted mid-frame (~pixel 5000): all outputs at reset values immediately, no done; new start yields pixel 0 with pix_sof.

Source files
------------

// File: rtl/rom_pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module      : rom_pixel_streamer
// Description : Reads a stored image from the on-chip image ROM and delivers
//               it as a raster-ordered RGB565 pixel stream with valid/ready
//               flow control. Addresses are issued only when the word buffer
//               is certain to have room for the returning word, so ROM data
//               is never dropped under backpressure. Each 32-bit word is
//               unpacked into two pixels, low half first.
// Ports       : clk, rst          - clock (shared with ROM), async active-high reset
//               start             - one-cycle pulse, begins a frame (IDLE only)
//               rom_addr          - registered ROM word address
//               rom_rd_data       - ROM read data, RD_LATENCY edges after rom_addr
//               pix_data/valid    - pixel stream, transfer = valid & ready
//               pix_ready         - downstream accept
//               pix_sof/eol/eof   - start-of-frame / end-of-line / end-of-frame
//               busy, done        - frame in progress / one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module rom_pixel_streamer #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int PIX_WIDTH  = 16,
    parameter int H_PIX      = 128,
    parameter int V_LINES    = 128,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rd_data,
    output logic [PIX_WIDTH-1:0]  pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_sof,
    output logic                  pix_eol,
    output logic                  pix_eof,
    output logic                  busy,
    output logic                  done
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_SUM_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
    localparam int c_X_W   = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam int c_Y_W   = (V_LINES > 1) ? $clog2(V_LINES) : 1;

    // Address issued on the edge that moves us into DRAIN is the last word.
    localparam logic [ADDR_WIDTH-1:0] c_PEN_ADDR = ADDR_WIDTH'((2 ** ADDR_WIDTH) - 2);
    localparam logic [c_X_W-1:0]      c_X_LAST   = c_X_W'(H_PIX - 1);
    localparam logic [c_Y_W-1:0]      c_Y_LAST   = c_Y_W'(V_LINES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [RD_LATENCY-1:0]  r_pipe;
    logic [DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic                   r_half;
    logic [c_X_W-1:0]       r_x;
    logic [c_Y_W-1:0]       r_y;
    logic                   r_done;

    logic [c_SUM_W-1:0]     w_inflight;
    logic [c_SUM_W-1:0]     w_used;
    logic                   w_start_acc;
    logic                   w_issue_run;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_valid;
    logic                   w_xfer;
    logic                   w_sof;
    logic                   w_eol;
    logic                   w_eof;
    logic [DATA_WIDTH-1:0]  w_head;

    // ------------------------------------------------------------------------
    // Credit: buffered words plus words still in the ROM pipe must never
    // exceed the buffer depth, so every returning word has a slot waiting.
    // ------------------------------------------------------------------------
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + c_SUM_W'(r_pipe[i]);
        end
    end

    assign w_used      = c_SUM_W'(r_count) + w_inflight;
    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_issue_run = (r_state == ST_RUN) && (w_used < c_SUM_W'(FIFO_DEPTH));
    assign w_push      = r_pipe[RD_LATENCY-1];
    assign w_valid     = (r_count != '0);
    assign w_xfer      = w_valid && pix_ready;
    assign w_pop       = w_xfer && r_half;
    assign w_head      = r_mem[r_rd_ptr];

    assign w_sof = w_valid && (r_x == '0) && (r_y == '0);
    assign w_eol = w_valid && (r_x == c_X_LAST);
    assign w_eof = w_eol && (r_y == c_Y_LAST);

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_issue_run && (r_addr == c_PEN_ADDR)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_xfer && w_eof) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Address issue and read-latency tracking. The start edge itself issues
    // address 0; each later issue advances the address by one.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_pipe <= '0;
        end else begin
            if (w_start_acc) begin
                r_addr <= '0;
            end else if (w_issue_run) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
            end
            r_pipe[0] <= w_start_acc || w_issue_run;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Word buffer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rom_rd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Unpack position and raster counters, advanced on every transfer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_half <= 1'b0;
            r_x    <= '0;
            r_y    <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DRAIN) && w_xfer && w_eof;
            if (w_start_acc) begin
                r_half <= 1'b0;
                r_x    <= '0;
                r_y    <= '0;
            end else if (w_xfer) begin
                r_half <= ~r_half;
                if (w_eol) begin
                    r_x <= '0;
                    r_y <= (r_y == c_Y_LAST) ? '0 : r_y + c_Y_W'(1);
                end else begin
                    r_x <= r_x + c_X_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        pix_data = '0;
        if (w_valid) begin
            pix_data = r_half ? w_head[PIX_WIDTH +: PIX_WIDTH] : w_head[PIX_WIDTH-1:0];
        end
    end

    assign rom_addr  = r_addr;
    assign pix_valid = w_valid;
    assign pix_sof   = w_sof;
    assign pix_eol   = w_eol;
    assign pix_eof   = w_eof;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rom_pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_pixel_streamer
// Description : Self-checking bench for rom_pixel_streamer. A ROM model with
//               random contents feeds the DUT; every accepted start pushes the
//               expected frame (pixels computed from ROM contents and raster
//               position) into a queue that a monitor drains on each transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_pixel_streamer;

    localparam int AW     = 13;
    localparam int DW     = 32;
    localparam int PW     = 16;
    localparam int H      = 128;
    localparam int V      = 128;
    localparam int RDL    = 2;
    localparam int FD     = 4;
    localparam int NWORDS = 2 ** AW;
    localparam int NPIX   = H * V;

    logic          clk       = 1'b0;
    logic          tb_rst    = 1'b1;
    logic          start     = 1'b0;
    logic          pix_ready = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_rd_data = '0;
    logic [PW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_sof;
    logic          pix_eol;
    logic          pix_eof;
    logic          busy;
    logic          done;

    int            checks   = 0;
    int            failures = 0;

    logic [DW-1:0] rom_mem [NWORDS];
    logic [PW+2:0] exp_q [$];          // {sof, eol, eof, data}

    int            rdy_mode   = 0;     // 0: always ready, 1: random 50%, 2: held low
    bit            contig_chk = 1'b0;
    bit            in_frame   = 1'b0;
    bit            done_due   = 1'b0;
    bit            stall_pend = 1'b0;
    logic [PW+2:0] stall_val;
    int            xfers      = 0;
    int            eol_cnt    = 0;

    rom_pixel_streamer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .PIX_WIDTH  (PW),
        .H_PIX      (H),
        .V_LINES    (V),
        .RD_LATENCY (RDL),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk         (clk),
        .rst         (tb_rst),
        .start       (start),
        .rom_addr    (rom_addr),
        .rom_rd_data (rom_rd_data),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_sof     (pix_sof),
        .pix_eol     (pix_eol),
        .pix_eof     (pix_eof),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // ROM model: data for the address presented is available to be captured
    // RD_LATENCY edges after the address changes.
    always @(posedge clk) rom_rd_data <= rom_mem[rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW+2:0] ref_pixel(input int p);
        logic [DW-1:0] w;
        logic [PW-1:0] d;
        w = rom_mem[p / 2];
        d = (p % 2 == 1) ? w[2*PW-1:PW] : w[PW-1:0];
        return {(p == 0), ((p % H) == H - 1), (p == NPIX - 1), d};
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_addr"},  32'(rom_addr), 0);
        chk({tag, "_data"},  32'(pix_data), 0);
        chk({tag, "_valid"}, 32'(pix_valid), 0);
        chk({tag, "_flags"}, 32'({pix_sof, pix_eol, pix_eof}), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(done), 0);
    endtask

    // Call right after a falling edge while the DUT is idle.
    task automatic do_start();
        start = 1'b1;
        for (int p = 0; p < NPIX; p++) exp_q.push_back(ref_pixel(p));
        xfers   = 0;
        eol_cnt = 0;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("start_addr", 32'(rom_addr), 0);
        chk("start_busy", 32'(busy), 1);
        chk("valid_lat1", 32'(pix_valid), 0);
        @(negedge clk);
        chk("valid_lat2", 32'(pix_valid), 0);
        @(negedge clk);
        chk("first_valid_sof", 32'({pix_valid, pix_sof}), 3);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < budget);
        chk("frame_done_seen", 32'(done), 1);
    endtask

    task automatic wait_pixels(input int target, input int budget);
        int n;
        n = 0;
        while (xfers < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("pixel_count_reached", 32'(xfers >= target), 1);
    endtask

    // Downstream ready generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = ($urandom_range(0, 1) == 1);
                default: pix_ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [PW+2:0] cur;
        int            outst;
        if (tb_rst) begin
            stall_pend = 1'b0;
            in_frame   = 1'b0;
            done_due   = 1'b0;
        end else begin
            cur = {pix_sof, pix_eol, pix_eof, pix_data};

            if (done_due) begin
                chk("done_pulse", 32'({done, busy}), 2);
                done_due = 1'b0;
            end else if (done) begin
                chk("spurious_done", 32'(done), 0);
            end

            if (stall_pend) chk("stall_hold", 32'({pix_valid, cur}), 32'({1'b1, stall_val}));
            if (contig_chk && in_frame) chk("contiguous", 32'(pix_valid), 1);

            if (busy) begin
                outst = int'(rom_addr) + 1 - xfers / 2;
                chk("occupancy_le_depth", 32'(outst <= FD), 1);
            end

            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pixel: got 0x%0h expected none at %0t", cur, $time);
                end else begin
                    chk("pixel", 32'(cur), 32'(exp_q.pop_front()));
                end
                xfers++;
                if (pix_sof) in_frame = 1'b1;
                if (pix_eol) eol_cnt++;
                if (pix_eof) begin
                    in_frame = 1'b0;
                    done_due = 1'b1;
                end
                stall_pend = 1'b0;
            end else if (pix_valid) begin
                stall_pend = 1'b1;
                stall_val  = cur;
            end else begin
                stall_pend = 1'b0;
            end
        end
    end

    initial begin
        for (int i = 0; i < NWORDS; i++) rom_mem[i] = $urandom;

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        tb_rst = 1'b0;
        @(negedge clk);

        // Frame A: ready held high, extra starts while busy are ignored
        rdy_mode   = 0;
        contig_chk = 1'b1;
        do_start();
        repeat (3) begin
            repeat ($urandom_range(500, 3000)) @(negedge clk);
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
        end
        wait_done(40000);
        chk("queue_drained_A", 32'(exp_q.size()), 0);
        chk("eol_count_A", 32'(eol_cnt), V);

        // Frame B: started in the done cycle; long stall, then random ready
        contig_chk = 1'b0;
        rdy_mode   = 2;
        do_start();
        repeat (100) @(negedge clk);
        chk("stall_addr", 32'(rom_addr), 3);
        chk("stall_pixel0", 32'({pix_valid, pix_sof, pix_data}), 32'({2'b11, exp_q[0][PW-1:0]}));
        rdy_mode = 1;
        wait_done(80000);
        chk("queue_drained_B", 32'(exp_q.size()), 0);
        chk("eol_count_B", 32'(eol_cnt), V);

        // Frame C: reset mid-frame aborts without done
        rdy_mode   = 0;
        contig_chk = 1'b1;
        repeat (5) @(negedge clk);
        do_start();
        wait_pixels(5000, 20000);
        #2 tb_rst = 1'b1;
        #1 check_reset_vals("abort");
        exp_q.delete();
        repeat (3) @(negedge clk);
        tb_rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("no_done_after_abort", 32'(done), 0);
        end

        // Frame D: restart after abort begins at pixel 0
        do_start();
        wait_pixels(300, 2000);
        @(negedge clk);
        #2 tb_rst = 1'b1;
        exp_q.delete();
        #1 check_reset_vals("final");
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
